ifetch_stage: RTL

Instruction fetch stage that sits directly upstream of the control/decode unit. Maintains the PC and issues in-order word requests to instruction memory. Buffers returned instructions in a small FIFO and presents them to the control unit with the opcode/funct3/funct7/register fields already split out. Downstream handshake is valid/ready; pipeline redirects come from the branch/jump logic.

---
 rtl/ifetch_stage.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC generation, credit-limited memory requests, response buffering and
// field split for the decode unit. Define IFETCH_PERF_EN to add the perf_fetch_cnt output.
module ifetch_stage #(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [31:0]         out_instr,
  output logic [6:0]          out_opcode,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic                out_rtype
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0]    ptr_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  pc_t  pc_q, pc_d;
  logic started_q;
  cnt_t outst_q, outst_d;
  cnt_t drop_q, drop_d;
  cnt_t fifo_cnt_q, fifo_cnt_d;
  ptr_t fifo_rd_q, fifo_rd_d;
  ptr_t fifo_wr_q, fifo_wr_d;
  ptr_t infl_rd_q, infl_rd_d;
  ptr_t infl_wr_q, infl_wr_d;

  pc_t         fifo_pc_q    [FIFO_DEPTH];
  logic [31:0] fifo_instr_q [FIFO_DEPTH];
  pc_t         infl_pc_q    [FIFO_DEPTH];

  logic [CNT_W:0] in_use;
  logic           req_fire;
  logic           drop_active;
  logic           push;
  logic           pop;
  logic [31:0]    head_instr;

  // Stale in-flight requests still hold credit, so the buffer can never overflow.
  assign in_use         = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
  assign imem_req_valid = started_q && !redirect_valid && (in_use < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign drop_active = (drop_q != '0);
  assign push        = imem_rsp_valid && !drop_active && !redirect_valid;
  assign out_valid   = (fifo_cnt_q != '0);
  assign pop         = out_valid && out_ready && !redirect_valid;

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    pc_d       = pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    fifo_cnt_d = fifo_cnt_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    infl_rd_d  = infl_rd_q;
    infl_wr_d  = infl_wr_q;

    if (redirect_valid) begin
      pc_d = redirect_pc & ~pc_t'(3);
    end else if (req_fire) begin
      pc_d = pc_q + pc_t'(4);
    end

    if (req_fire && !imem_rsp_valid) begin
      outst_d = outst_q + cnt_t'(1);
    end else if (!req_fire && imem_rsp_valid) begin
      outst_d = outst_q - cnt_t'(1);
    end

    // After a redirect every request still in flight is stale; pending drops are a subset of them.
    if (redirect_valid) begin
      drop_d = imem_rsp_valid ? outst_q - cnt_t'(1) : outst_q;
    end else if (imem_rsp_valid && drop_active) begin
      drop_d = drop_q - cnt_t'(1);
    end

    if (redirect_valid) begin
      fifo_cnt_d = '0;
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
    end else begin
      if (push) fifo_wr_d = fifo_wr_q + ptr_t'(1);
      if (pop)  fifo_rd_d = fifo_rd_q + ptr_t'(1);
      if (push && !pop) begin
        fifo_cnt_d = fifo_cnt_q + cnt_t'(1);
      end else if (pop && !push) begin
        fifo_cnt_d = fifo_cnt_q - cnt_t'(1);
      end
    end

    if (req_fire)       infl_wr_d = infl_wr_q + ptr_t'(1);
    if (imem_rsp_valid) infl_rd_d = infl_rd_q + ptr_t'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      started_q  <= 1'b0;
      outst_q    <= '0;
      drop_q     <= '0;
      fifo_cnt_q <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      infl_rd_q  <= '0;
      infl_wr_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      started_q  <= 1'b1;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      infl_rd_q  <= infl_rd_d;
      infl_wr_q  <= infl_wr_d;
    end
  end

  // NOTE: storage arrays carry no reset; entries are only read while the pointers mark them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[fifo_wr_q]    <= infl_pc_q[infl_rd_q];
      fifo_instr_q[fifo_wr_q] <= imem_rsp_data;
    end
    if (req_fire) begin
      infl_pc_q[infl_wr_q] <= pc_q;
    end
  end

  assign head_instr = out_valid ? fifo_instr_q[fifo_rd_q] : '0;
  assign out_pc     = out_valid ? fifo_pc_q[fifo_rd_q] : '0;
  assign out_instr  = head_instr;
  assign out_opcode = head_instr[6:0];
  assign out_rd     = head_instr[11:7];
  assign out_funct3 = head_instr[14:12];
  assign out_rs1    = head_instr[19:15];
  assign out_rs2    = head_instr[24:20];
  assign out_funct7 = head_instr[31:25];
  assign out_rtype  = out_valid && (head_instr[6:0] == 7'b0110011);

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (pop) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_q;
`endif

endmodule
